// File: rtl/tbt_accumulator.sv
// Initiator-side sequencer that folds a stream of 2x2 FP32 matrices into a running sum via an external 2x2 adder.
// Optional watchdog on the adder handshake is enabled by defining TBT_ACC_TIMEOUT_EN.
module tbt_accumulator #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [127:0]       in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               add_A_stb,
  output logic               add_B_stb,
  output logic [127:0]       add_A,
  output logic [127:0]       add_B,
  input  logic               add_result_ready,
  input  logic [127:0]       add_result,
  output logic               add_result_ack,
  output logic               sum_valid,
  output logic [127:0]       sum_data,
  output logic [COUNT_W-1:0] sum_count,
  output logic               sum_err,
  input  logic               sum_ack
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCEPT  = 3'd1,
    S_ISSUE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [127:0]         acc_r;
  logic [127:0]         op_r;
  logic [COUNT_W-1:0]   count_r;
  logic                 last_f_r;
  logic                 stb_r;
  logic                 ack_r;
  logic                 valid_r;
  logic                 tmr_hit_s;

  // Next-state decode; the awaited handshake edge always wins over the watchdog.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid) state_s = in_last ? S_DONE : S_ACCEPT;
        else          state_s = S_IDLE;
      end
      S_ACCEPT: begin
        if (in_valid) state_s = S_ISSUE;
        else          state_s = S_ACCEPT;
      end
      S_ISSUE: begin
        if (add_result_ready) state_s = S_RELEASE;
        else if (tmr_hit_s)   state_s = S_DONE;
        else                  state_s = S_ISSUE;
      end
      S_RELEASE: begin
        if (!add_result_ready) state_s = last_f_r ? S_DONE : S_ACCEPT;
        else if (tmr_hit_s)    state_s = S_DONE;
        else                   state_s = S_RELEASE;
      end
      S_DONE: begin
        if (sum_ack) state_s = S_IDLE;
        else         state_s = S_DONE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Datapath: accumulator, pending operand, saturating matrix count and last flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= 128'd0;
      op_r     <= 128'd0;
      count_r  <= '0;
      last_f_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            acc_r   <= in_data;
            count_r <= COUNT_W'(1);
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            op_r     <= in_data;
            last_f_r <= in_last;
            if (count_r != {COUNT_W{1'b1}}) count_r <= count_r + COUNT_W'(1);
          end
        end
        S_ISSUE: begin
          if (add_result_ready) acc_r <= add_result;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_r   <= 1'b0;
      ack_r   <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      stb_r   <= (state_s == S_ISSUE);
      ack_r   <= (state_s == S_RELEASE);
      valid_r <= (state_s == S_DONE);
    end
  end

`ifdef TBT_ACC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmr_r;
  logic          err_r;
  logic          wait_s;
  logic          err_set_s;

  assign wait_s    = (state_r == S_ISSUE) || (state_r == S_RELEASE);
  assign tmr_hit_s = wait_s && (tmr_r == TW'(TIMEOUT - 1));
  assign err_set_s = tmr_hit_s &&
                     (((state_r == S_ISSUE) && !add_result_ready) ||
                      ((state_r == S_RELEASE) && add_result_ready));

  // Watchdog restarts on every state change so each handshake phase gets the full budget.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              tmr_r <= '0;
    else if (wait_s && (state_s == state_r)) tmr_r <= tmr_r + TW'(1);
    else                                     tmr_r <= '0;
  end

  // Error flag sticks until the consumer acknowledges the aborted sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 err_r <= 1'b0;
    else if (err_set_s)                         err_r <= 1'b1;
    else if ((state_r == S_DONE) && sum_ack)    err_r <= 1'b0;
    else                                        err_r <= err_r;
  end

  assign sum_err = err_r;
`else
  assign tmr_hit_s = 1'b0;
  assign sum_err   = 1'b0;
`endif

  // in_ready is gated by reset so it reads 0 while reset is held, 1 immediately after release.
  assign in_ready       = reset && ((state_r == S_IDLE) || (state_r == S_ACCEPT));
  assign add_A_stb      = stb_r;
  assign add_B_stb      = stb_r;
  assign add_A          = acc_r;
  assign add_B          = op_r;
  assign add_result_ack = ack_r;
  assign sum_valid      = valid_r;
  assign sum_data       = acc_r;
  assign sum_count      = count_r;

endmodule
